// File: rtl/ex_div_unit_pkg.sv
// Shared definitions for the EX-stage divider: state encoding, width and op selects.
package ex_div_unit_pkg;

  localparam int unsigned DIV_W = 32;

  // Divider FSM states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StDzero = 2'd2,
    StDone  = 2'd3
  } div_state_e;

  // SPECIAL-opcode funct fields the EX decode uses to select DIV / DIVU.
  localparam logic [5:0] FunctDiv  = 6'b011010;
  localparam logic [5:0] FunctDivu = 6'b011011;

endpackage

// File: rtl/ex_div_unit_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
module ex_div_unit_div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic              dividend_msb_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] next_rem_o,
  output logic              q_bit_o
);

  logic              shift_top;
  logic [DATA_W-1:0] shift_low;
  logic              borrow;
  logic [DATA_W-1:0] diff;

  // A set bit shifted out of rem means the trial value exceeds any divisor, so the
  // subtraction only needs the low DATA_W bits (the carry-out is absorbed by the wrap).
  always_comb begin
    {shift_top, shift_low} = {rem_i, dividend_msb_i};
    {borrow, diff}         = {1'b0, shift_low} - {1'b0, divisor_i};
    q_bit_o                = shift_top | ~borrow;
    next_rem_o             = q_bit_o ? diff : shift_low;
  end

endmodule

// File: rtl/ex_div_unit.sv
// Multi-cycle 32-bit DIV/DIVU unit for the EX stage; holds the pipeline via
// stallreq_for_ex until the quotient/remainder are presented.
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_W,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_start,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              cancel,
  output logic              stallreq_for_ex,
  output logic              result_valid,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam logic [CNT_W-1:0] LastIter = CNT_W'(DATA_W - 1);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dvd_q, dvd_d;   // dividend shifts out MSB-first, quotient shifts in
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic [DATA_W-1:0] quo_hold_q, quo_hold_d;
  logic [DATA_W-1:0] rem_hold_q, rem_hold_d;

  logic [DATA_W-1:0] abs_a, abs_b;
  logic [DATA_W-1:0] step_rem;
  logic              step_q;
  logic [DATA_W-1:0] quo_fix, rem_fix;

  ex_div_unit_div_step #(
    .DATA_W (DATA_W)
  ) u_div_step (
    .rem_i          (rem_q),
    .dividend_msb_i (dvd_q[DATA_W-1]),
    .divisor_i      (dvs_q),
    .next_rem_o     (step_rem),
    .q_bit_o        (step_q)
  );

  // Operand magnitudes and sign-corrected results.
  always_comb begin
    abs_a   = (div_signed && op_a[DATA_W-1]) ? -op_a : op_a;
    abs_b   = (div_signed && op_b[DATA_W-1]) ? -op_b : op_b;
    quo_fix = q_neg_q ? -dvd_q : dvd_q;
    rem_fix = r_neg_q ? -rem_q : rem_q;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    quo_hold_d = quo_hold_q;
    rem_hold_d = rem_hold_q;

    unique case (state_q)
      StIdle: begin
        if (div_start && !cancel) begin
          cnt_d = '0;
          if (op_b == '0) begin
            // Fixed divide-by-zero result, no sign correction.
            state_d = StDzero;
            dvd_d   = '1;
            rem_d   = op_a;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
          end else begin
            state_d = StBusy;
            dvd_d   = abs_a;
            dvs_d   = abs_b;
            rem_d   = '0;
            q_neg_d = div_signed & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
            r_neg_d = div_signed & op_a[DATA_W-1];
          end
        end
      end
      StBusy: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[DATA_W-2:0], step_q};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LastIter) begin
          state_d = StDone;
        end
      end
      StDzero: state_d = StDone;
      StDone: begin
        state_d = StIdle;
        if (!cancel) begin
          quo_hold_d = quo_fix;
          rem_hold_d = rem_fix;
        end
      end
      default: state_d = StIdle;
    endcase

    if (cancel) begin
      state_d = StIdle;
    end
  end

  // Outputs: results shown live in DONE, held afterwards; stall gated by reset too.
  always_comb begin
    result_valid    = (state_q == StDone) && !cancel;
    stallreq_for_ex = (((state_q == StIdle) && div_start) || (state_q == StBusy) ||
                       (state_q == StDzero)) && !cancel && rst;
    quotient        = result_valid ? quo_fix : quo_hold_q;
    remainder       = result_valid ? rem_fix : rem_hold_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      quo_hold_q <= '0;
      rem_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      quo_hold_q <= quo_hold_d;
      rem_hold_q <= rem_hold_d;
    end
  end

endmodule
